// File: rtl/mips_multicycle_ctrl_if.sv
// Control-unit boundary for the multicycle MIPS datapath.
// The master side is the controller; the slave side is the IR/ALU/datapath.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes aluop/funct into the 3-bit ALU control code.
//
// state    | meaning
// ---------+-------------------------------------------------
// FETCH    | read instruction at PC into IR, PC <= PC + 4
// DECODE   | read registers, precompute branch target
// MEMADR   | compute lw/sw effective address
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write memory data to rt
// MEMWRITE | write B to data memory at ALUOut
// EXECUTE  | R-type ALU operation on A, B
// ALUWB    | write ALUOut to rd
// BRANCH   | compare A - B, load branch target if zero
// ADDIEXEC | A + sign-extended immediate
// ADDIWB   | write ALUOut to rt
// JUMP     | load jump target into PC
module mips_multicycle_ctrl #(
    parameter logic [2:0] BAD_FUNCT_ALUCTL = 3'b010
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_ctrl_if.master     bus
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] ADDIEXEC = 4'd9;
    localparam logic [3:0] ADDIWB   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] dec_state;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       memwrite_raw;
    logic       irwrite_raw;
    logic       regwrite_raw;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEXEC;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTE:  next_state = ALUWB;
            ADDIEXEC: next_state = ADDIWB;
            default:  next_state = FETCH;
        endcase
    end

    // During reset the datapath controls look like FETCH, whatever the stored state.
    assign dec_state = reset ? FETCH : state;

    always_comb begin
        bus.iord     = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        regwrite_raw = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        aluop        = ALUOP_ADD;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        case (dec_state)
            FETCH: begin
                irwrite_raw = 1'b1;
                bus.alusrcb = 2'b01;
                pcwrite     = 1'b1;
            end
            DECODE: bus.alusrcb = 2'b11;
            MEMADR, ADDIEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMREAD: bus.iord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_raw = 1'b1;
            end
            MEMWRITE: begin
                bus.iord     = 1'b1;
                memwrite_raw = 1'b1;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                regwrite_raw = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
            end
            ADDIWB: regwrite_raw = 1'b1;
            JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.memwrite = memwrite_raw & ~reset;
    assign bus.irwrite  = irwrite_raw & ~reset;
    assign bus.regwrite = regwrite_raw & ~reset;
    assign bus.pcen     = (pcwrite | (branch & bus.zero)) & ~reset;

    always_comb begin
        bus.alucontrol = 3'b010;
        case (aluop)
            ALUOP_SUB: bus.alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                case (bus.funct)
                    6'h20:   bus.alucontrol = 3'b010;
                    6'h22:   bus.alucontrol = 3'b110;
                    6'h24:   bus.alucontrol = 3'b000;
                    6'h25:   bus.alucontrol = 3'b001;
                    6'h2A:   bus.alucontrol = 3'b111;
                    default: bus.alucontrol = BAD_FUNCT_ALUCTL;
                endcase
            end
            default: bus.alucontrol = 3'b010;
        endcase
    end

endmodule
